// File: rtl/sw_mem_loader.sv
// sw_mem_loader
//   Hand-entry writer for the processor's instruction/data memory. A debounced
//   push-button steps through address entry, data entry and a single-cycle
//   write, auto-incrementing the address so consecutive words can be keyed in.
//   The processor is held in reset whenever the loader is active.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   load_en     loader mode switch (1 = loading, 0 = processor runs)
//   key_n       raw push-button, active-low, asynchronous, bouncy
//   sw_data     switch value: address (low ADDR_W bits) or data word
//   mem_wren    memory write strobe, one cycle per word
//   mem_addr    memory write address
//   mem_data    memory write data
//   proc_hold   1 = hold processor in reset
//   state       FSM state code for LEDs (IDLE 00, ADDR 01, DATA 10, WRITE 11)
//   wrapped     sticky: address auto-increment wrapped past the top word
//
// Build option LOADER_READBACK_EN
//   Adds input mem_q (1-cycle read latency at mem_addr) and sticky output
//   verify_err. Each write is followed by a VERIFY cycle (state code 11) that
//   compares mem_q with mem_data before the address advances. verify_err is
//   cleared when ADDR is entered.

module sw_mem_loader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              key_n,
    input  logic [DATA_W-1:0] sw_data,
`ifdef LOADER_READBACK_EN
    input  logic [DATA_W-1:0] mem_q,
    output logic              verify_err,
`endif
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              proc_hold,
    output logic [1:0]        state,
    output logic              wrapped
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // Low two bits are the displayed code; VERIFY shares code 11 with WRITE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_ADDR   = 3'b001,
        S_DATA   = 3'b010,
        S_WRITE  = 3'b011,
        S_VERIFY = 3'b111
    } state_t;

`ifdef LOADER_READBACK_EN
    localparam state_t LAST_STEP = S_VERIFY;
`else
    localparam state_t LAST_STEP = S_WRITE;
`endif

    state_t           st;
    logic             key_s1;
    logic             key_s2;
    logic             key_deb;
    logic             key_deb_q;
    logic [CNT_W-1:0] deb_cnt;
    logic             press;

    // Key path: 2-FF synchroniser, then a level debouncer that only accepts a
    // new level after DEB_CYCLES consecutive samples differing from the
    // current debounced level. Idle level everywhere is "released" (1).
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, whatever the order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            key_deb   <= 1'b1;
            key_deb_q <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            key_s1    <= key_n;
            key_s2    <= key_s1;
            key_deb_q <= key_deb;
            if (key_s2 == key_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                key_deb <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    // One-cycle pulse on the debounced falling edge; release makes no event.
    assign press = key_deb_q & ~key_deb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            proc_hold <= 1'b0;
            wrapped   <= 1'b0;
`ifdef LOADER_READBACK_EN
            verify_err <= 1'b0;
`endif
        end else begin
            mem_wren <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (load_en) begin
                        st        <= S_ADDR;
                        proc_hold <= 1'b1;
`ifdef LOADER_READBACK_EN
                        verify_err <= 1'b0;
`endif
                    end else begin
                        proc_hold <= 1'b0;
                    end
                end
                // Dropping load_en mid-entry discards the partial input.
                S_ADDR: begin
                    if (!load_en) begin
                        st        <= S_IDLE;
                        proc_hold <= 1'b0;
                    end else if (press) begin
                        mem_addr <= sw_data[ADDR_W-1:0];
                        wrapped  <= 1'b0;
                        st       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!load_en) begin
                        st        <= S_IDLE;
                        proc_hold <= 1'b0;
                    end else if (press) begin
                        mem_data <= sw_data;
                        mem_wren <= 1'b1;
                        st       <= S_WRITE;
                    end
                end
                // The write cycle (and verify, if present) always completes;
                // load_en is only honoured once the address has advanced.
                S_WRITE, S_VERIFY: begin
                    if (st != LAST_STEP) begin
                        st <= S_VERIFY;
                    end else begin
`ifdef LOADER_READBACK_EN
                        if (mem_q != mem_data) begin
                            verify_err <= 1'b1;
                        end
`endif
                        mem_addr <= mem_addr + ADDR_W'(1);
                        if (&mem_addr) begin
                            wrapped <= 1'b1;
                        end
                        if (load_en) begin
                            st <= S_DATA;
                        end else begin
                            st        <= S_IDLE;
                            proc_hold <= 1'b0;
                        end
                    end
                end
                default: begin
                    st        <= S_IDLE;
                    proc_hold <= 1'b0;
                end
            endcase
        end
    end

    assign state = st[1:0];

endmodule

// File: tb/tb_sw_mem_loader.sv
// tb_sw_mem_loader
//   Self-checking bench for sw_mem_loader with DEB_CYCLES=4: reset, a table of
//   hand-computed entry transactions, multi-cycle debounce/abort sequences and
//   randomized entry checked against an abstract memory model.

module tb_sw_mem_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEB    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_en;
    logic              key_n;
    logic [DATA_W-1:0] sw_data;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              proc_hold;
    logic [1:0]        state;
    logic              wrapped;
`ifdef LOADER_READBACK_EN
    logic [DATA_W-1:0] mem_q;
    logic              verify_err;
    logic [DATA_W-1:0] corrupt = '0;
    logic [DATA_W-1:0] ram [32];
`endif

    always #5 clk = ~clk;

    sw_mem_loader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .key_n     (key_n),
        .sw_data   (sw_data),
`ifdef LOADER_READBACK_EN
        .mem_q     (mem_q),
        .verify_err(verify_err),
`endif
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .proc_hold (proc_hold),
        .state     (state),
        .wrapped   (wrapped)
    );

`ifdef LOADER_READBACK_EN
    // Write-first synchronous RAM with optional bit corruption on read.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= (mem_wren ? mem_data : ram[mem_addr]) ^ corrupt;
    end
`endif

    int errors = 0;
    int checks = 0;

    // Write monitor, sampled on the falling edge.
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [DATA_W-1:0] last_wdata = '0;
    logic [DATA_W-1:0] dut_mem [32];

    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            wr_count++;
            last_waddr = mem_addr;
            last_wdata = mem_data;
            dut_mem[mem_addr] = mem_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are checked 1 time unit after a falling edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [DATA_W-1:0] v);
        sw_data = v;
        key_n   = 1'b0;
        cycles(8);
        key_n   = 1'b1;
        cycles(8);
    endtask

    task automatic reload();
        load_en = 1'b0;
        cycles(2);
        load_en = 1'b1;
        cycles(2);
    endtask

    typedef struct {
        bit                new_addr;
        logic [DATA_W-1:0] a_sw;
        logic [DATA_W-1:0] d_sw;
        logic [ADDR_W-1:0] exp_waddr;
        logic [ADDR_W-1:0] exp_next;
        bit                exp_wrapped;
    } vec_t;

    vec_t vecs [7];

    // Abstract reference for the random phase: a word array and a cursor.
    logic [DATA_W-1:0] m_mem [32];
    int                m_addr;
    bit                m_wrapped;

    initial begin
        int                w0;
        int                op;
        logic [DATA_W-1:0] r;

        vecs[0] = '{1'b1, 16'h0003, 16'hA5F0, 5'd3,  5'd4,  1'b0};
        vecs[1] = '{1'b0, 16'h0000, 16'h1111, 5'd4,  5'd5,  1'b0};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h1234, 5'd31, 5'd0,  1'b1};
        vecs[3] = '{1'b0, 16'h0000, 16'hBEEF, 5'd0,  5'd1,  1'b1};
        vecs[4] = '{1'b1, 16'h0042, 16'h0000, 5'd2,  5'd3,  1'b0};
        vecs[5] = '{1'b1, 16'h001E, 16'h7777, 5'd30, 5'd31, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 16'h8888, 5'd31, 5'd0,  1'b1};

        // Reset
        rst_n   = 1'b0;
        load_en = 1'b0;
        key_n   = 1'b1;
        sw_data = '0;
        cycles(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_hold", 32'(proc_hold), 32'd0);
        check("rst_wrapped", 32'(wrapped), 32'd0);
`ifdef LOADER_READBACK_EN
        check("rst_verify_err", 32'(verify_err), 32'd0);
`endif
        rst_n = 1'b1;
        cycles(1);
        check("idle_state", 32'(state), 32'd0);
        load_en = 1'b1;
        cycles(1);
        check("enter_addr_state", 32'(state), 32'd1);
        check("enter_addr_hold", 32'(proc_hold), 32'd1);

        // Table of entry transactions
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].new_addr) begin
                reload();
                press(vecs[i].a_sw);
                check($sformatf("v%0d_addr_latched", i), 32'(mem_addr), 32'(vecs[i].exp_waddr));
                check($sformatf("v%0d_addr_wrapped_clr", i), 32'(wrapped), 32'd0);
            end
            check($sformatf("v%0d_in_data", i), 32'(state), 32'd2);
            w0 = wr_count;
            press(vecs[i].d_sw);
            check($sformatf("v%0d_one_write", i), 32'(wr_count - w0), 32'd1);
            check($sformatf("v%0d_waddr", i), 32'(last_waddr), 32'(vecs[i].exp_waddr));
            check($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].d_sw));
            check($sformatf("v%0d_next_addr", i), 32'(mem_addr), 32'(vecs[i].exp_next));
            check($sformatf("v%0d_wrapped", i), 32'(wrapped), 32'(vecs[i].exp_wrapped));
            check($sformatf("v%0d_state", i), 32'(state), 32'd2);
            check($sformatf("v%0d_wren_idle", i), 32'(mem_wren), 32'd0);
        end

        // Bouncy key: two 3-cycle glitches, then stable low for 10 cycles
        reload();
        w0      = wr_count;
        sw_data = 16'h0007;
        for (int g = 0; g < 2; g++) begin
            key_n = 1'b0;
            cycles(3);
            key_n = 1'b1;
            cycles(3);
        end
        check("glitch_ignored", 32'(state), 32'd1);
        key_n = 1'b0;
        cycles(6);
        check("deb_before_latency", 32'(state), 32'd1);
        cycles(1);
        check("deb_at_latency_state", 32'(state), 32'd2);
        check("deb_at_latency_addr", 32'(mem_addr), 32'd7);
        cycles(3);
        key_n = 1'b1;
        cycles(8);
        check("deb_single_press", 32'(state), 32'd2);
        check("deb_no_write", 32'(wr_count - w0), 32'd0);

        // load_en dropped in DATA before the data press
        load_en = 1'b0;
        cycles(1);
        check("abort_state", 32'(state), 32'd0);
        check("abort_hold", 32'(proc_hold), 32'd0);
        press(16'h5555);
        check("abort_no_write", 32'(wr_count - w0), 32'd0);
        check("abort_still_idle", 32'(state), 32'd0);
        load_en = 1'b1;
        cycles(1);
        check("reenter_state", 32'(state), 32'd1);
        check("reenter_keeps_addr", 32'(mem_addr), 32'd7);
        check("reenter_keeps_data", 32'(mem_data), 32'h8888);

`ifdef LOADER_READBACK_EN
        check("verify_clean", 32'(verify_err), 32'd0);
        corrupt = 16'h0001;
        reload();
        press(16'h0005);
        press(16'hCAFE);
        check("verify_err_set", 32'(verify_err), 32'd1);
        check("verify_addr_adv", 32'(mem_addr), 32'd6);
        corrupt = 16'h0000;
        reload();
        check("verify_err_clr", 32'(verify_err), 32'd0);
`endif

        // Randomized entry against the abstract model
        for (int i = 0; i < 32; i++) begin
            m_mem[i]   = '0;
            dut_mem[i] = '0;
        end
        m_addr    = 0;
        m_wrapped = 1'b0;
        for (int n = 0; n < 40; n++) begin
            op = (n == 0) ? 0 : int'($urandom_range(0, 3));
            r  = DATA_W'($urandom);
            if (op == 0) begin
                reload();
                press(r);
                m_addr    = int'(r) % 32;
                m_wrapped = 1'b0;
                check($sformatf("rnd%0d_addr", n), 32'(mem_addr), 32'(m_addr));
            end else begin
                w0 = wr_count;
                press(r);
                m_mem[m_addr] = r;
                if (m_addr == 31) m_wrapped = 1'b1;
                m_addr = (m_addr + 1) % 32;
                check($sformatf("rnd%0d_one_write", n), 32'(wr_count - w0), 32'd1);
                check($sformatf("rnd%0d_next_addr", n), 32'(mem_addr), 32'(m_addr));
                check($sformatf("rnd%0d_wrapped", n), 32'(wrapped), 32'(m_wrapped));
                check($sformatf("rnd%0d_state", n), 32'(state), 32'd2);
            end
        end
        for (int i = 0; i < 32; i++) begin
            check($sformatf("mem[%0d]", i), 32'(dut_mem[i]), 32'(m_mem[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
